dmem_mmio: RTL
==============

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, UART bit period in clk cycles (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, UART TX FIFO entries (power of two, <=8).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets at the clk edge).
REQ-006 SHALL have port MemWrite  input  1  store strobe from core data port.
REQ-007 SHALL have port Addr  input  32  byte address (core ALUResult).
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port ReadData  output  32  load data, combinational from Addr and current state.
REQ-010 SHALL have port uart_tx  output  1  serial 8N1 transmit line, idle high.

Function
REQ-011 SHALL decode word accesses only; Addr[1:0] ignored.
REQ-012 SHALL map RAM at 0x0000_0000 to RAM_WORDS*4-1, indexed by Addr[log2(RAM_WORDS)+1:2]; async read, write at edge when MemWrite=1.
REQ-013 SHALL map TXDATA at 0x1000_0000: write pushes WriteData[7:0]; read returns 0.
REQ-014 SHALL map STATUS at 0x1000_0004: read [0]=full, [1]=empty, [2]=tx_busy, [7:4]=fifo count, others 0; write with WriteData[0]=1 flushes FIFO.
REQ-015 SHALL map CYCLE at 0x1000_0008: read returns counter; write loads WriteData.
REQ-016 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-017 SHALL make ReadData reflect pre-edge state; a same-cycle write is not visible until the next cycle.
REQ-018 SHALL evaluate full on the registered count; a push while full is dropped even if a pop occurs the same cycle.
REQ-019 SHALL leave count unchanged on simultaneous accepted push and pop.
REQ-020 SHALL give flush priority over pop: count becomes 0; the byte popped that cycle is still transmitted.
REQ-021 SHALL implement TX FSM IDLE -> START -> DATA -> STOP, each bit held CLKS_PER_BIT cycles; DATA sends 8 bits LSB first.
REQ-022 SHALL, in IDLE with FIFO non-empty, pop and enter START at that edge; uart_tx low from that edge.
REQ-023 SHALL, at end of STOP, pop and enter START directly if FIFO non-empty (no idle gap), else enter IDLE.
REQ-024 SHALL drive uart_tx: IDLE=1, START=0, DATA=current bit, STOP=1; registered output.
REQ-025 SHALL assert tx_busy in every state except IDLE.
REQ-026 SHALL increment CYCLE by 1 each cycle, wrapping 0xFFFF_FFFF -> 0; a write load takes priority over increment that cycle.

Reset
REQ-027 SHALL on reset clear FIFO (empty=1, count=0), set FSM IDLE, bit/cycle counters 0, uart_tx=1, CYCLE=0.
REQ-028 SHALL not reset RAM contents.
REQ-029 SHALL, on reset mid-frame, abort the frame with uart_tx=1 from the reset edge; FIFO contents lost.
REQ-030 SHALL ignore MemWrite during reset cycles.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to 0x0000_0010, read same addr next cycle -> 0xDEADBEEF; same-cycle read -> old value.
REQ-032 SHALL cover: push 0x55 with FIFO empty, FSM idle -> uart_tx low one edge later, then bits 1,0,1,0,1,0,1,0, stop 1; total 10*CLKS_PER_BIT cycles low-to-idle.
REQ-033 SHALL cover: push 9 bytes in 9 consecutive cycles while idle -> first popped after push 1, 8 held, none dropped; 10 pushes with no pops -> 10th dropped, STATUS[0]=1, [7:4]=8.
REQ-034 SHALL cover: two queued bytes -> second START begins immediately after first STOP, no idle cycle.
REQ-035 SHALL cover: write CYCLE=0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
REQ-036 SHALL cover: reset asserted mid-DATA -> uart_tx=1, STATUS=0x0000_0002, CYCLE=0 at next cycle.

Source files
------------

// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data memory for a small core, with a memory-mapped
// 8N1 UART transmitter (byte FIFO + serializer) and a free-running cycle counter.
//   0x0000_0000 .. RAM_WORDS*4-1 : RAM (async read, write on clk edge)
//   0x1000_0000 TXDATA  : write pushes WriteData[7:0], reads 0
//   0x1000_0004 STATUS  : {24'b0, count[3:0], 1'b0, tx_busy, empty, full}; write bit0=1 flushes
//   0x1000_0008 CYCLE   : read counter, write loads it
module dmem_mmio #(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [29:0]   TXDATA_WORD = 30'h0400_0000;
  localparam logic [29:0]   STATUS_WORD = 30'h0400_0001;
  localparam logic [29:0]   CYCLE_WORD  = 30'h0400_0002;
  localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COUNT_EMPTY = CW'(0);
  localparam logic [BW-1:0] BIT_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_LAST    = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // circular pointer advance that also works for non-power-of-two wrap points
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PTR_LAST) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- decode
  logic ram_sel_s, txdata_sel_s, status_sel_s, cycle_sel_s;
  logic unused_addr_s;

  assign ram_sel_s     = (Addr[31:AW+2] == {(30-AW){1'b0}});
  assign txdata_sel_s  = (Addr[31:2] == TXDATA_WORD);
  assign status_sel_s  = (Addr[31:2] == STATUS_WORD);
  assign cycle_sel_s   = (Addr[31:2] == CYCLE_WORD);
  assign unused_addr_s = ^Addr[1:0];

  // ---------------------------------------------------------------- state
  logic [31:0]   ram_r [RAM_WORDS];
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   cycle_r;

  tx_state_t     state_r;
  logic [BW-1:0] clk_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;

  logic full_s, empty_s, push_s, pop_s, flush_s, bit_end_s, tx_busy_s;
  logic [31:0] status_s;

  // full/empty come from the registered count, so a push while full is lost
  // even when the serializer pops in the same cycle
  assign full_s    = (count_r == COUNT_FULL);
  assign empty_s   = (count_r == COUNT_EMPTY);
  assign push_s    = MemWrite & txdata_sel_s & ~full_s;
  assign flush_s   = MemWrite & status_sel_s & WriteData[0];
  assign bit_end_s = (clk_cnt_r == BIT_LAST);
  assign tx_busy_s = (state_r != TX_IDLE);
  assign pop_s     = ~empty_s & ((state_r == TX_IDLE) | ((state_r == TX_STOP) & bit_end_s));
  assign status_s  = {24'h00_0000, 4'(count_r), 1'b0, tx_busy_s, empty_s, full_s};
  assign uart_tx   = tx_r;

  // RAM store port; contents are intentionally kept across reset
  always_ff @(posedge clk) begin
    if (reset && MemWrite && ram_sel_s) begin
      ram_r[Addr[AW+1:2]] <= WriteData;
    end
  end

  // FIFO byte storage; only the pointers/count are reset
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      fifo_mem_r[wr_ptr_r] <= WriteData[7:0];
    end
  end

  // FIFO pointers and occupancy; flush overrides everything, push+pop holds count
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= COUNT_EMPTY;
    end else if (flush_s) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= COUNT_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // serializer: frame sequencing, bit timing and the registered line driver;
  // a byte popped here is latched into shift_r, so a same-cycle flush cannot lose it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= TX_IDLE;
      clk_cnt_r <= {BW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          clk_cnt_r <= {BW{1'b0}};
          if (!empty_s) begin
            state_r <= TX_START;
            shift_r <= fifo_mem_r[rd_ptr_r];
            tx_r    <= 1'b0;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end_s) begin
            clk_cnt_r <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            state_r   <= TX_DATA;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
          end else begin
            clk_cnt_r <= clk_cnt_r + BW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= {BW{1'b0}};
            if (bit_idx_r == 3'd7) begin
              state_r <= TX_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + BW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= {BW{1'b0}};
            if (!empty_s) begin
              state_r <= TX_START;
              shift_r <= fifo_mem_r[rd_ptr_r];
              tx_r    <= 1'b0;
            end else begin
              state_r <= TX_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r   <= TX_IDLE;
          clk_cnt_r <= {BW{1'b0}};
          tx_r      <= 1'b1;
        end
      endcase
    end
  end

  // cycle counter: a software load wins over the increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_r <= 32'h0000_0000;
    end else if (MemWrite && cycle_sel_s) begin
      cycle_r <= WriteData;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // load data mux; reflects pre-edge state, TXDATA and unmapped read as zero
  always_comb begin
    ReadData = 32'h0000_0000;
    if (ram_sel_s) begin
      ReadData = ram_r[Addr[AW+1:2]];
    end else if (status_sel_s) begin
      ReadData = status_s;
    end else if (cycle_sel_s) begin
      ReadData = cycle_r;
    end else begin
      ReadData = 32'h0000_0000;
    end
  end

endmodule
